// File: rtl/cheri_pkg.sv
// Shared types and constants for the CHERI temporal-safety (revocation) map.
package cheri_pkg;

    typedef enum logic {
        TSMAP_INIT,
        TSMAP_RUN
    } tsmap_state_e;

    // Each bitmap bit covers one 8-byte heap granule.
    localparam int TSMAP_GRAN_SHIFT = 3;

endpackage

// File: rtl/cheri_tsmap_ram.sv
// Single-port bitmap storage with per-byte write enables and a registered read.
// Kept separate so the array can later be swapped for an SRAM macro.
module cheri_tsmap_ram #(
    parameter int Depth = 1024,
    parameter int AW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] r_mem [Depth];

    // Like a real macro the read register only updates on read accesses.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_i[k]) begin
                        r_mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_o <= r_mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/cheri_tsmap_ctrl.sv
// Temporal-safety bitmap owner: init sweep, fixed-latency revocation read port and
// a req/gnt/rvalid bus port, arbitrating one storage access per cycle.
module cheri_tsmap_ctrl
    import cheri_pkg::*;
#(
    parameter int          TSMapSize = 1024,
    parameter logic [31:0] TSMapBase = 32'h8300_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tsmap_cs_i,
    input  logic [15:0] tsmap_addr_i,
    output logic [31:0] tsmap_rdata_o,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [3:0]  bus_be_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic        bus_gnt_o,
    output logic        bus_rvalid_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_err_o,
    output logic        init_done_o
);

    localparam int            AW      = (TSMapSize > 1) ? $clog2(TSMapSize) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(TSMapSize - 1);

    tsmap_state_e  r_state;
    logic [AW-1:0] r_cnt;
    logic          r_initDone;
    logic          r_csHit;
    logic [31:0]   r_tsHold;
    logic          r_rvalid;
    logic          r_err;
    logic          r_busRdHit;

    logic          w_tsHit;
    logic [31:0]   w_busOffs;
    logic [31:0]   w_busIdx;
    logic          w_busInRange;
    logic          w_busHit;
    logic          w_ramEn;
    logic          w_ramWe;
    logic [3:0]    w_ramBe;
    logic [AW-1:0] w_ramAddr;
    logic [31:0]   w_ramWdata;
    logic [31:0]   w_ramRdata;

    assign w_tsHit      = tsmap_cs_i && (r_state == TSMAP_RUN) &&
                          (32'(tsmap_addr_i) < 32'(TSMapSize));
    // Addresses below the base wrap to a huge index and fall out of range.
    assign w_busOffs    = bus_addr_i - TSMapBase;
    assign w_busIdx     = w_busOffs >> 2;
    assign w_busInRange = w_busIdx < 32'(TSMapSize);
    assign bus_gnt_o    = bus_req_i & r_initDone & ~tsmap_cs_i;
    assign w_busHit     = bus_gnt_o & w_busInRange;

    always_comb begin
        w_ramEn    = 1'b0;
        w_ramWe    = 1'b0;
        w_ramBe    = 4'h0;
        w_ramAddr  = '0;
        w_ramWdata = 32'h0;
        if (r_state == TSMAP_INIT) begin
            if (!tsmap_cs_i) begin
                w_ramEn   = 1'b1;
                w_ramWe   = 1'b1;
                w_ramBe   = 4'hF;
                w_ramAddr = r_cnt;
            end
        end else if (w_tsHit) begin
            w_ramEn   = 1'b1;
            w_ramAddr = tsmap_addr_i[AW-1:0];
        end else if (w_busHit) begin
            w_ramEn    = 1'b1;
            w_ramWe    = bus_we_i;
            w_ramBe    = bus_be_i;
            w_ramAddr  = w_busIdx[AW-1:0];
            w_ramWdata = bus_wdata_i;
        end
    end

    cheri_tsmap_ram #(
        .Depth (TSMapSize),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (w_ramEn),
        .we_i    (w_ramWe),
        .be_i    (w_ramBe),
        .addr_i  (w_ramAddr),
        .wdata_i (w_ramWdata),
        .rdata_o (w_ramRdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= TSMAP_INIT;
            r_cnt      <= '0;
            r_initDone <= 1'b0;
            r_csHit    <= 1'b0;
            r_tsHold   <= 32'h0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_busRdHit <= 1'b0;
        end else begin
            r_initDone <= (r_state == TSMAP_RUN);
            if ((r_state == TSMAP_INIT) && !tsmap_cs_i) begin
                if (r_cnt == LastIdx) begin
                    r_state <= TSMAP_RUN;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // The hold register shadows the visible read data so it survives bus reads.
            r_csHit    <= w_tsHit;
            r_tsHold   <= tsmap_cs_i ? 32'h0 : tsmap_rdata_o;
            r_rvalid   <= bus_gnt_o;
            r_err      <= bus_gnt_o & ~w_busInRange;
            r_busRdHit <= w_busHit & ~bus_we_i;
        end
    end

    assign tsmap_rdata_o = r_csHit ? w_ramRdata : r_tsHold;
    assign bus_rdata_o   = r_busRdHit ? w_ramRdata : 32'h0;
    assign bus_rvalid_o  = r_rvalid;
    assign bus_err_o     = r_err;
    assign init_done_o   = r_initDone;

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// Self-checking bench for cheri_tsmap_ctrl: directed vector table, reset/sweep
// sequences and randomized traffic against a word-array reference model.
module tb_cheri_tsmap_ctrl;

    localparam int          N = 1024;
    localparam logic [31:0] B = 32'h8300_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tsmap_cs_i = 1'b0;
    logic [15:0] tsmap_addr_i = 16'h0;
    logic [31:0] tsmap_rdata_o;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [3:0]  bus_be_i = 4'h0;
    logic [31:0] bus_addr_i = 32'h0;
    logic [31:0] bus_wdata_i = 32'h0;
    logic        bus_gnt_o;
    logic        bus_rvalid_o;
    logic [31:0] bus_rdata_o;
    logic        bus_err_o;
    logic        init_done_o;

    always #5 clk_i = ~clk_i;

    cheri_tsmap_ctrl #(
        .TSMapSize (N),
        .TSMapBase (B)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tsmap_cs_i    (tsmap_cs_i),
        .tsmap_addr_i  (tsmap_addr_i),
        .tsmap_rdata_o (tsmap_rdata_o),
        .bus_req_i     (bus_req_i),
        .bus_we_i      (bus_we_i),
        .bus_be_i      (bus_be_i),
        .bus_addr_i    (bus_addr_i),
        .bus_wdata_i   (bus_wdata_i),
        .bus_gnt_o     (bus_gnt_o),
        .bus_rvalid_o  (bus_rvalid_o),
        .bus_rdata_o   (bus_rdata_o),
        .bus_err_o     (bus_err_o),
        .init_done_o   (init_done_o)
    );

    typedef struct {
        logic        cs;
        logic [15:0] ta;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] ba;
        logic [31:0] wd;
        logic        eGnt;
        logic        eRv;
        logic        eErr;
        logic [31:0] eBrd;
        logic        chkTs;
        logic [31:0] eTs;
    } vec_t;

    vec_t        tbl [18];
    int          checks = 0;
    int          passes = 0;
    logic        sGnt = 1'b0, sRv = 1'b0, sErr = 1'b0, sDone = 1'b0;
    logic [31:0] sBrd = 32'h0, sTs = 32'h0;
    logic [31:0] mem [N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock cycle: drive just after an edge, sample grant mid-cycle and the
    // registered responses just after the following edge.
    task automatic applyStimulus(input logic cs, input logic [15:0] ta, input logic req,
                                 input logic we, input logic [3:0] be,
                                 input logic [31:0] ba, input logic [31:0] wd);
        tsmap_cs_i   = cs;
        tsmap_addr_i = ta;
        bus_req_i    = req;
        bus_we_i     = we;
        bus_be_i     = be;
        bus_addr_i   = ba;
        bus_wdata_i  = wd;
        #1;
        sGnt = bus_gnt_o;
        @(posedge clk_i);
        #1;
        sRv   = bus_rvalid_o;
        sErr  = bus_err_o;
        sBrd  = bus_rdata_o;
        sTs   = tsmap_rdata_o;
        sDone = init_done_o;
    endtask

    function automatic logic [31:0] genBusAddr();
        int unsigned r;
        int unsigned idx;
        r = $urandom_range(0, 15);
        if (r == 0) return B + 32'd4096 + 32'($urandom_range(0, 255) * 4);
        if (r == 1) return B - 32'($urandom_range(1, 8) * 4);
        if (r == 2) return 32'($urandom);
        idx = (r < 12) ? $urandom_range(0, 15) : $urandom_range(0, N - 1);
        return B + 32'(idx * 4) + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [15:0] genTsAddr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 16'(N + $urandom_range(0, 60000));
        if (r < 12) return 16'($urandom_range(0, 15));
        return 16'($urandom_range(0, N - 1));
    endfunction

    initial begin
        int   cyc;
        int   badGnt;
        logic [31:0] tsDuringInit;

        // cs, ta, req, we, be, ba, wd, eGnt, eRv, eErr, eBrd, chkTs, eTs
        tbl[0]  = '{1'b0, 16'd0,     1'b1, 1'b1, 4'hF, B + 32'd20,   32'hA5A5_0F0F, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[1]  = '{1'b1, 16'd5,     1'b1, 1'b1, 4'h2, B + 32'd20,   32'h0000_FF00, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_0F0F};
        tbl[2]  = '{1'b0, 16'd0,     1'b1, 1'b1, 4'h2, B + 32'd20,   32'h0000_FF00, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hA5A5_0F0F};
        tbl[3]  = '{1'b1, 16'd5,     1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_FF0F};
        tbl[4]  = '{1'b0, 16'd0,     1'b1, 1'b0, 4'h0, B + 32'd20,   32'h0,         1'b1, 1'b1, 1'b0, 32'hA5A5_FF0F, 1'b1, 32'hA5A5_FF0F};
        tbl[5]  = '{1'b0, 16'd0,     1'b1, 1'b0, 4'h0, B + 32'd4096, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
        tbl[6]  = '{1'b0, 16'd0,     1'b1, 1'b1, 4'hF, B - 32'd4,    32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
        tbl[7]  = '{1'b1, 16'd1024,  1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{1'b0, 16'd0,     1'b1, 1'b1, 4'h9, B + 32'hFFF,  32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b1, 16'd1023,  1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1200_0078};
        tbl[10] = '{1'b0, 16'd0,     1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1200_0078};
        tbl[11] = '{1'b0, 16'd0,     1'b1, 1'b1, 4'h0, B + 32'd20,   32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1200_0078};
        tbl[12] = '{1'b0, 16'd0,     1'b1, 1'b0, 4'h0, B + 32'd20,   32'h0,         1'b1, 1'b1, 1'b0, 32'hA5A5_FF0F, 1'b1, 32'h1200_0078};
        tbl[13] = '{1'b0, 16'd0,     1'b1, 1'b0, 4'h0, B,            32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[14] = '{1'b1, 16'd1023,  1'b1, 1'b0, 4'h0, B + 32'd20,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1200_0078};
        tbl[15] = '{1'b0, 16'd0,     1'b1, 1'b0, 4'h0, B + 32'd20,   32'h0,         1'b1, 1'b1, 1'b0, 32'hA5A5_FF0F, 1'b1, 32'h1200_0078};
        tbl[16] = '{1'b1, 16'd65535, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[17] = '{1'b0, 16'd0,     1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0};

        // Reset values, then time the init sweep with the read port idle.
        bus_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("reset gnt", 32'(bus_gnt_o), 32'h0);
        checkOutput("reset rvalid", 32'(bus_rvalid_o), 32'h0);
        checkOutput("reset err", 32'(bus_err_o), 32'h0);
        checkOutput("reset bus_rdata", bus_rdata_o, 32'h0);
        checkOutput("reset ts_rdata", tsmap_rdata_o, 32'h0);
        checkOutput("reset init_done", 32'(init_done_o), 32'h0);
        bus_req_i = 1'b0;
        rst_i     = 1'b0;
        cyc = 0;
        while (!sDone && cyc < 3000) begin
            applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            cyc++;
        end
        checkOutput("init latency", 32'(cyc), 32'(N + 1));

        applyStimulus(1'b1, 16'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("post-init read idx0", sTs, 32'h0);
        applyStimulus(1'b1, 16'd777, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("post-init read idx777", sTs, 32'h0);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].cs, tbl[i].ta, tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].ba, tbl[i].wd);
            checkOutput($sformatf("row%0d gnt", i), 32'(sGnt), 32'(tbl[i].eGnt));
            checkOutput($sformatf("row%0d rvalid", i), 32'(sRv), 32'(tbl[i].eRv));
            if (tbl[i].eRv) begin
                checkOutput($sformatf("row%0d err", i), 32'(sErr), 32'(tbl[i].eErr));
                checkOutput($sformatf("row%0d bus_rdata", i), sBrd, tbl[i].eBrd);
            end
            if (tbl[i].chkTs) checkOutput($sformatf("row%0d ts_rdata", i), sTs, tbl[i].eTs);
        end

        // Reset part-way through a sweep: it must restart from word 0 and keep the bus locked out.
        rst_i = 1'b1;
        #2;
        checkOutput("rst1 init_done", 32'(init_done_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_req_i = 1'b1;
        rst_i     = 1'b1;
        #2;
        checkOutput("rst2 gnt", 32'(bus_gnt_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sDone = 1'b0;
        cyc = 0;
        badGnt = 0;
        tsDuringInit = 32'hDEAD_BEEF;
        while (!sDone && cyc < 3000) begin
            applyStimulus(cyc == 10, 16'd1023, 1'b1, 1'b0, 4'h0, B + 32'd20, 32'h0);
            if (sGnt) badGnt++;
            if (cyc == 10) tsDuringInit = sTs;
            cyc++;
        end
        checkOutput("resweep latency with stall", 32'(cyc), 32'(N + 2));
        checkOutput("gnt during sweep", 32'(badGnt), 32'h0);
        checkOutput("read during sweep", tsDuringInit, 32'h0);
        applyStimulus(1'b0, 16'd0, 1'b1, 1'b0, 4'h0, B + 32'd20, 32'h0);
        checkOutput("first gnt after sweep", 32'(sGnt), 32'h1);
        checkOutput("bus read idx5 after sweep", sBrd, 32'h0);
        applyStimulus(1'b1, 16'd1023, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("read idx1023 after sweep", sTs, 32'h0);
        applyStimulus(1'b1, 16'd5, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("read idx5 after sweep", sTs, 32'h0);

        // Randomized mixed traffic against a plain word-array model of the map.
        begin
            logic        cs, req, we, eGnt, eErr, pending, tsKnown;
            logic [15:0] ta;
            logic [3:0]  be;
            logic [31:0] ba, wd, eBrd, eTs, idx;
            for (int i = 0; i < N; i++) mem[i] = 32'h0;
            pending = 1'b0;
            tsKnown = 1'b0;
            req = 1'b0; we = 1'b0; be = 4'h0; ba = 32'h0; wd = 32'h0;
            eTs = 32'h0;
            for (int c = 0; c < 10000; c++) begin
                cs = ($urandom_range(0, 2) == 0);
                ta = genTsAddr();
                if (!pending) begin
                    req = ($urandom_range(0, 1) == 1);
                    we  = ($urandom_range(0, 1) == 1);
                    be  = 4'($urandom);
                    ba  = genBusAddr();
                    wd  = $urandom;
                end
                eGnt = req && !cs;
                eErr = 1'b0;
                eBrd = 32'h0;
                if (cs) begin
                    eTs = (32'(ta) < N) ? mem[int'(ta)] : 32'h0;
                    tsKnown = 1'b1;
                end
                if (eGnt) begin
                    idx  = (ba - B) >> 2;
                    eErr = (idx >= N);
                    if (!eErr && !we) eBrd = mem[int'(idx)];
                    if (!eErr && we) begin
                        for (int k = 0; k < 4; k++)
                            if (be[k]) mem[int'(idx)][8*k +: 8] = wd[8*k +: 8];
                    end
                end
                pending = req && !eGnt;
                applyStimulus(cs, ta, req, we, be, ba, wd);
                checkOutput($sformatf("rand%0d gnt", c), 32'(sGnt), 32'(eGnt));
                checkOutput($sformatf("rand%0d rvalid", c), 32'(sRv), 32'(eGnt));
                if (eGnt) begin
                    checkOutput($sformatf("rand%0d err", c), 32'(sErr), 32'(eErr));
                    checkOutput($sformatf("rand%0d bus_rdata", c), sBrd, eBrd);
                end
                if (tsKnown) checkOutput($sformatf("rand%0d ts_rdata", c), sTs, eTs);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
